mem_bus_arbiter: RTL and testbench

Shares the single-port unified memory bus between the instruction-fetch port (IF) and the load/store port (MEM) of the pipelined MIPS core. It arbitrates with MEM priority and a bounded IF-starvation guard, and registers the winning request onto the bus. It routes `bus_ack`/`bus_rdata` back to the owner. It sits between the IF/MEM pipeline stages and the memory. It produces per-port stall signals for the hazard logic.

---
 rtl/mem_bus_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the unified memory bus between IF and MEM.
// MEM has priority; a bounded counter keeps IF from starving.
module mem_bus_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_stall,
   input  logic              mem_req,
   input  logic [3:0]        mem_wea,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              mem_ack,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_stall,
   output logic              bus_req,
   output logic [3:0]        bus_wea,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_ack,
   input  logic [DATA_W-1:0] bus_rdata
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] OWN_IF  = 2'd1;
   localparam logic [1:0] OWN_MEM = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic              bus_req_q, bus_req_d;
   logic [3:0]        bus_wea_q, bus_wea_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;

   logic is_idle, is_if, is_mem;
   logic arb_en, if_cand, mem_cand;
   logic grant_if, grant_mem;

   assign is_idle = (state_q == IDLE);
   assign is_if   = (state_q == OWN_IF);
   assign is_mem  = (state_q == OWN_MEM);

   // Arbitrate when idle, or in an owner's completion cycle
   // with the completing port dropped from the candidates.
   always_comb begin
      arb_en    = is_idle | ((is_if | is_mem) & bus_ack);
      if_cand   = arb_en & if_req & ~is_if;
      mem_cand  = arb_en & mem_req & ~is_mem;
      grant_if  = if_cand & (~mem_cand | (starve_q == SMAX));
      grant_mem = mem_cand & ~grant_if;
   end

   // Next state, starvation count and bus register loads.
   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      bus_req_d   = bus_req_q;
      bus_wea_d   = bus_wea_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      if (grant_if) begin
         state_d     = OWN_IF;
         starve_d    = '0;
         bus_req_d   = 1'b1;
         bus_wea_d   = 4'b0000;
         bus_addr_d  = if_addr;
         bus_wdata_d = '0;
      end else if (grant_mem) begin
         state_d     = OWN_MEM;
         bus_req_d   = 1'b1;
         bus_wea_d   = mem_wea;
         bus_addr_d  = mem_addr;
         bus_wdata_d = mem_wdata;
         if (if_req && starve_q != SMAX)
            starve_d = starve_q + SW'(1);
      end else if (arb_en) begin
         state_d   = IDLE;
         bus_req_d = 1'b0;
      end
   end

   // State and bus registers, cleared asynchronously.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         starve_q    <= '0;
         bus_req_q   <= 1'b0;
         bus_wea_q   <= 4'b0000;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         bus_req_q   <= bus_req_d;
         bus_wea_q   <= bus_wea_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
      end
   end

   // Completion routing back to the owning port.
   always_comb begin
      if_ack    = is_if & bus_ack;
      mem_ack   = is_mem & bus_ack;
      if_rdata  = bus_rdata;
      mem_rdata = bus_rdata;
      if_stall  = if_req & ~if_ack;
      mem_stall = mem_req & ~mem_ack;
   end

   assign bus_req   = bus_req_q;
   assign bus_wea   = bus_wea_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of the IF/MEM bus arbiter.
// Inputs change just after posedge; outputs sampled at negedge.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        if_stall;
   logic        mem_req;
   logic [3:0]  mem_wea;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        mem_stall;
   logic        bus_req;
   logic [3:0]  bus_wea;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   int checks = 0;
   int errors = 0;

   mem_bus_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)
   ) dut (
      .clk(clk), .resetn(resetn),
      .if_req(if_req), .if_addr(if_addr),
      .if_ack(if_ack), .if_rdata(if_rdata),
      .if_stall(if_stall),
      .mem_req(mem_req), .mem_wea(mem_wea),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .mem_stall(mem_stall),
      .bus_req(bus_req), .bus_wea(bus_wea),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got 0 exp 1");
      $fatal(1, "timeout");
   end

   logic [10:0] v_ifq, v_mack, v_iack;
   int n_mem_before_if;
   bit seen_if;

   initial begin
      resetn    = 1'b0;
      if_req    = 1'b0;
      if_addr   = '0;
      mem_req   = 1'b0;
      mem_wea   = 4'b0000;
      mem_addr  = '0;
      mem_wdata = '0;
      bus_ack   = 1'b0;
      bus_rdata = '0;
      smp();
      chk("rst_bus_req", bus_req, 0);
      chk("rst_bus_wea", bus_wea, 0);
      chk("rst_bus_addr", bus_addr, 0);
      chk("rst_bus_wdata", bus_wdata, 0);
      chk("rst_acks", {if_ack, mem_ack}, 0);
      chk("rst_state", dut.state_q, 0);
      chk("rst_starve", dut.starve_q, 0);
      resetn = 1'b1;

      // single fetch, zero-wait
      nxt();
      if_req  = 1'b1;
      if_addr = 32'h0040_0000;
      smp();
      chk("f_c0_bus_req", bus_req, 0);
      chk("f_c0_if_stall", if_stall, 1);
      nxt();
      bus_ack   = 1'b1;
      bus_rdata = 32'h8C08_0004;
      smp();
      chk("f_c1_bus_req", bus_req, 1);
      chk("f_c1_bus_wea", bus_wea, 0);
      chk("f_c1_bus_addr", bus_addr, 32'h0040_0000);
      chk("f_c1_if_ack", if_ack, 1);
      chk("f_c1_if_rdata", if_rdata, 32'h8C08_0004);
      chk("f_c1_if_stall", if_stall, 0);
      chk("f_c1_mem_ack", mem_ack, 0);
      nxt();
      if_req  = 1'b0;
      bus_ack = 1'b0;
      smp();
      chk("f_c2_state", dut.state_q, 0);
      chk("f_c2_bus_req", bus_req, 0);
      chk("f_c2_addr_keep", bus_addr, 32'h0040_0000);

      // simultaneous requests
      nxt();
      if_req    = 1'b1;
      if_addr   = 32'h0040_0004;
      mem_req   = 1'b1;
      mem_wea   = 4'b1111;
      mem_addr  = 32'h1001_0000;
      mem_wdata = 32'hDEAD_BEEF;
      smp();
      nxt();
      bus_ack   = 1'b1;
      bus_rdata = 32'h0;
      smp();
      chk("s_c1_mem_ack", mem_ack, 1);
      chk("s_c1_if_ack", if_ack, 0);
      chk("s_c1_wdata", bus_wdata, 32'hDEAD_BEEF);
      chk("s_c1_wea", bus_wea, 4'b1111);
      chk("s_c1_addr", bus_addr, 32'h1001_0000);
      chk("s_c1_starve", dut.starve_q, 1);
      chk("s_c1_if_stall", if_stall, 1);
      nxt();
      mem_req   = 1'b0;
      bus_rdata = 32'h1234_5678;
      smp();
      chk("s_c2_bus_req", bus_req, 1);
      chk("s_c2_if_ack", if_ack, 1);
      chk("s_c2_addr", bus_addr, 32'h0040_0004);
      chk("s_c2_wea", bus_wea, 0);
      chk("s_c2_wdata", bus_wdata, 0);
      chk("s_c2_starve", dut.starve_q, 0);
      nxt();
      if_req  = 1'b0;
      bus_ack = 1'b0;
      smp();
      chk("s_c3_state", dut.state_q, 0);

      // starvation guard: IF withdraws in MEM ack cycles so
      // every arbitration with both pending happens in IDLE
      v_ifq  = 11'b00101010101;
      v_mack = 11'b10010101010;
      v_iack = 11'b01000000000;
      n_mem_before_if = 0;
      seen_if = 1'b0;
      mem_wea  = 4'b0011;
      mem_addr = 32'h1001_0010;
      for (int c = 0; c < 11; c++) begin
         nxt();
         if_req  = v_ifq[c];
         mem_req = (c < 10);
         bus_ack = 1'b1;
         smp();
         chk($sformatf("g_c%0d_mem_ack", c), mem_ack, v_mack[c]);
         chk($sformatf("g_c%0d_if_ack", c), if_ack, v_iack[c]);
         if (c == 8)
            chk("g_c8_starve", dut.starve_q, 4);
         if (if_ack) seen_if = 1'b1;
         if (mem_ack && !seen_if) n_mem_before_if++;
      end
      chk("g_mem_before_if", n_mem_before_if, 4);
      nxt();
      if_req  = 1'b0;
      mem_req = 1'b0;
      bus_ack = 1'b0;
      smp();
      chk("g_end_state", dut.state_q, 0);

      // wait states on a MEM read
      nxt();
      mem_req  = 1'b1;
      mem_wea  = 4'b0000;
      mem_addr = 32'h1001_0100;
      smp();
      for (int c = 1; c <= 3; c++) begin
         nxt();
         mem_addr = 32'h2000_0000 + c;
         if_req   = c[0];
         smp();
         chk($sformatf("w_c%0d_addr", c), bus_addr, 32'h1001_0100);
         chk($sformatf("w_c%0d_wea", c), bus_wea, 0);
         chk($sformatf("w_c%0d_stall", c), mem_stall, 1);
         chk($sformatf("w_c%0d_ack", c), mem_ack, 0);
      end
      nxt();
      if_req    = 1'b0;
      bus_ack   = 1'b1;
      bus_rdata = 32'hCAFE_F00D;
      smp();
      chk("w_c4_mem_ack", mem_ack, 1);
      chk("w_c4_rdata", mem_rdata, 32'hCAFE_F00D);
      chk("w_c4_stall", mem_stall, 0);
      nxt();
      mem_req = 1'b0;
      bus_ack = 1'b0;
      smp();
      chk("w_c5_state", dut.state_q, 0);

      // reset in the middle of a MEM write
      nxt();
      if_req    = 1'b1;
      mem_req   = 1'b1;
      mem_wea   = 4'b1111;
      mem_addr  = 32'h1001_0200;
      mem_wdata = 32'h5555_AAAA;
      smp();
      nxt();
      smp();
      chk("r_pre_bus_req", bus_req, 1);
      chk("r_pre_starve", dut.starve_q, 1);
      #1;
      if_req = 1'b0;
      resetn = 1'b0;
      #1;
      chk("r_bus_req", bus_req, 0);
      chk("r_starve", dut.starve_q, 0);
      chk("r_mem_ack", mem_ack, 0);
      chk("r_bus_wea", bus_wea, 0);
      smp();
      resetn = 1'b1;
      nxt();
      bus_ack = 1'b1;
      smp();
      chk("r_c1_bus_req", bus_req, 1);
      chk("r_c1_addr", bus_addr, 32'h1001_0200);
      chk("r_c1_mem_ack", mem_ack, 1);
      nxt();
      mem_req = 1'b0;
      bus_ack = 1'b0;
      smp();

      // stray ack in IDLE
      nxt();
      bus_ack = 1'b1;
      smp();
      chk("x_acks", {if_ack, mem_ack}, 0);
      nxt();
      smp();
      chk("x_state", dut.state_q, 0);
      chk("x_bus_req", bus_req, 0);
      chk("x_acks2", {if_ack, mem_ack}, 0);
      bus_ack = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
